// File: rtl/mat4x2_pkg.sv
// Shared constants and types for the streaming 4x2-by-2x2 matrix multiplier.
// Holds the operand-register map (A elements first, then B) and the FSM state type.
package mat4x2_pkg;

  localparam int unsigned N_ELEM = 12;  // operands per matrix pair
  localparam int unsigned N_A    = 8;   // elements of the 4x2 matrix A
  localparam int unsigned N_RES  = 8;   // dot products per matrix pair

  localparam int unsigned A_BASE = 0;   // A0..A7 occupy operand regs 0..7
  localparam int unsigned B_BASE = 8;   // B0..B3 occupy operand regs 8..11

  typedef enum logic {
    LOAD,
    OUT
  } state_e;

endpackage

// File: rtl/mat4x2_stream_mul_dot2_mul.sv
// Combinational two-term unsigned dot product: s = a0*b0 + a1*b1.
// Ports:
//   i_a0, i_b0, i_a1, i_b1 : DW-bit unsigned operands
//   o_s                    : (2*DW+1)-bit sum, wide enough that it never wraps
module dot2_mul #(
  parameter int unsigned DW = 4
) (
  input  logic [DW-1:0]   i_a0,
  input  logic [DW-1:0]   i_b0,
  input  logic [DW-1:0]   i_a1,
  input  logic [DW-1:0]   i_b1,
  output logic [2*DW:0]   o_s
);

  logic [2*DW-1:0] w_p0;
  logic [2*DW-1:0] w_p1;

  always_comb begin
    w_p0 = i_a0 * i_b0;
    w_p1 = i_a1 * i_b1;
    // Zero-extend both products before adding so the carry is kept.
    o_s  = {1'b0, w_p0} + {1'b0, w_p1};
  end

endmodule

// File: rtl/mat4x2_stream_mul.sv
// Streaming 4x2-by-2x2 matrix multiplier.
// Loads A0..A7 then B0..B3 one element per input handshake, then emits the
// eight results S_k = A[2r]*B[c] + A[2r+1]*B[c+2] (r = k>>1, c = k&1) one per
// output handshake. Loading and draining never overlap.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   in_valid/in_ready/in_data      : operand input stream
//   out_valid/out_ready/out_data   : result output stream
//   out_idx               : index k of the presented result
//   out_last              : high while S7 is presented
//   busy                  : high from first accepted operand until S7 handshake
module mat4x2_stream_mul
  import mat4x2_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned OW = 2 * DW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [2:0]    out_idx,
  output logic          out_last,
  output logic          busy
);

  state_e          r_state;
  state_e          w_state_d;
  logic [3:0]      r_cnt;
  logic [DW-1:0]   r_ops [N_ELEM];
  logic [OW-1:0]   r_out_data;
  logic [2:0]      r_out_idx;

  logic            w_in_hs;
  logic            w_out_hs;
  logic            w_load_done;
  logic [DW-1:0]   w_ops [N_ELEM];
  logic [2:0]      w_k;
  logic [3:0]      w_ia0;
  logic [3:0]      w_ia1;
  logic [3:0]      w_ib0;
  logic [3:0]      w_ib1;
  logic [2*DW:0]   w_dot;

  always_comb begin
    in_ready    = (r_state == LOAD);
    out_valid   = (r_state == OUT);
    out_data    = r_out_data;
    out_idx     = r_out_idx;
    out_last    = (r_out_idx == 3'd7) & out_valid;
    busy        = (r_state == OUT) | (r_cnt != 4'd0);
    w_in_hs     = in_valid & in_ready;
    w_out_hs    = out_valid & out_ready;
    w_load_done = w_in_hs & (r_cnt == 4'(N_ELEM - 1));
  end

  // Operand view with the element being accepted this cycle forwarded in, so
  // S0 can be formed on the same edge that captures B3.
  always_comb begin
    w_ops = r_ops;
    if (w_in_hs) begin
      w_ops[r_cnt] = in_data;
    end
  end

  // Next result index: 0 when leaving LOAD, k+1 while draining.
  always_comb begin
    w_k   = (r_state == LOAD) ? 3'd0 : r_out_idx + 3'd1;
    w_ia0 = 4'(A_BASE) + {1'b0, w_k[2:1], 1'b0};
    w_ia1 = 4'(A_BASE) + {1'b0, w_k[2:1], 1'b1};
    w_ib0 = 4'(B_BASE) + {3'b000, w_k[0]};
    w_ib1 = 4'(B_BASE) + 4'd2 + {3'b000, w_k[0]};
  end

  dot2_mul #(
    .DW (DW)
  ) u_dot2_mul (
    .i_a0 (w_ops[w_ia0]),
    .i_b0 (w_ops[w_ib0]),
    .i_a1 (w_ops[w_ia1]),
    .i_b1 (w_ops[w_ib1]),
    .o_s  (w_dot)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      LOAD: if (w_load_done) w_state_d = OUT;
      OUT:  if (w_out_hs && r_out_idx == 3'd7) w_state_d = LOAD;
      default: w_state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LOAD;
      r_cnt      <= 4'd0;
      r_out_data <= '0;
      r_out_idx  <= 3'd0;
      for (int i = 0; i < N_ELEM; i++) begin
        r_ops[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      if (w_in_hs) begin
        r_ops[r_cnt] <= in_data;
        r_cnt        <= w_load_done ? 4'd0 : r_cnt + 4'd1;
      end
      if (w_load_done) begin
        r_out_data <= OW'(w_dot);
        r_out_idx  <= 3'd0;
      end else if (w_out_hs && r_out_idx != 3'd7) begin
        r_out_data <= OW'(w_dot);
        r_out_idx  <= w_k;
      end
    end
  end

endmodule

// File: tb/tb_mat4x2_stream_mul.sv
module tb_mat4x2_stream_mul;

  localparam int DW = 4;
  localparam int OW = 2 * DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [2:0]    out_idx;
  logic          out_last;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int a [8];
  int b [4];

  mat4x2_stream_mul #(
    .DW (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: S_k straight from the matrix product definition.
  function automatic int ref_s(input int k);
    int r = k / 2;
    int c = k % 2;
    return a[2*r] * b[c] + a[2*r+1] * b[c+2];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Send the first n operands; optional bubble before each beat.
  task automatic send(input int n, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        step();
        check("busy_bubble", busy, (i != 0));
      end
      in_valid = 1'b1;
      in_data  = (i < 8) ? 4'(a[i]) : 4'(b[i-8]);
      check("in_ready_load", in_ready, 1);
      check("out_valid_load", out_valid, 0);
      step();
      if (i == 0) check("busy_rise", busy, 1);
    end
    in_valid = 1'b0;
    if (n == 12) check("latency", out_valid, 1);
  endtask

  // Drain n_take results; stall for stall_len cycles while result stall_k is shown.
  task automatic drain(input int stall_k, input int stall_len, input int n_take);
    for (int k = 0; k < n_take; k++) begin
      out_ready = 1'b1;
      check("out_valid", out_valid, 1);
      check("out_idx", out_idx, k);
      check($sformatf("out_data_k%0d", k), out_data, ref_s(k));
      check("out_last", out_last, (k == 7));
      check("in_ready_out", in_ready, 0);
      check("busy_out", busy, 1);
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          in_valid = 1'b1;  // must be ignored while draining
          step();
          check("stall_valid", out_valid, 1);
          check("stall_idx", out_idx, k);
          check("stall_data", out_data, ref_s(k));
          check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      if (k < n_take - 1 || n_take == 8) step();
    end
    out_ready = 1'b0;
    if (n_take == 8) begin
      check("done_valid", out_valid, 0);
      check("done_in_ready", in_ready, 1);
      check("done_busy", busy, 0);
    end
  endtask

  initial begin
    int mixed_exp [8];
    mixed_exp = '{7, 10, 15, 22, 23, 34, 31, 46};

    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);

    // Identity
    for (int i = 0; i < 8; i++) a[i] = i;
    b = '{1, 0, 0, 1};
    for (int k = 0; k < 8; k++) check("ident_model", ref_s(k), k);
    send(12, 1'b0);
    drain(-1, 0, 8);

    // Max values
    for (int i = 0; i < 8; i++) a[i] = 15;
    b = '{15, 15, 15, 15};
    send(12, 1'b0);
    check("max_450", out_data, 450);
    drain(-1, 0, 8);

    // Mixed values, with backpressure on S2
    a = '{1, 2, 3, 4, 5, 6, 7, 8};
    b = '{1, 2, 3, 4};
    for (int k = 0; k < 8; k++) check("mixed_model", ref_s(k), mixed_exp[k]);
    send(12, 1'b0);
    drain(2, 3, 8);

    // Input bubbles
    send(12, 1'b1);
    drain(-1, 0, 8);

    // Reset mid-load, then a fresh identity matrix
    for (int i = 0; i < 8; i++) a[i] = i + 3;
    b = '{2, 7, 5, 1};
    send(5, 1'b0);
    do_reset();
    check("midload_in_ready", in_ready, 1);
    check("midload_busy", busy, 0);
    for (int i = 0; i < 8; i++) a[i] = i;
    b = '{1, 0, 0, 1};
    send(12, 1'b0);
    drain(-1, 0, 8);

    // Reset during OUT at k=4
    send(12, 1'b0);
    drain(-1, 0, 5);
    do_reset();
    check("midout_valid", out_valid, 0);
    check("midout_in_ready", in_ready, 1);
    check("midout_busy", busy, 0);
    check("midout_idx", out_idx, 0);

    // Randomized matrices, bubbles and stalls
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) a[i] = int'($urandom_range(15, 0));
      for (int i = 0; i < 4; i++) b[i] = int'($urandom_range(15, 0));
      send(12, 1'($urandom_range(1, 0)));
      drain(int'($urandom_range(8, 0)), int'($urandom_range(4, 1)), 8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
